// File: rtl/mc_req_arbiter_pkg.sv
// mc_req_arbiter_pkg: shared widths, read-flag offset, grant/slot encodings and request payload
`ifndef REGULAR_READ_OFS
`define REGULAR_READ_OFS 0
`endif
package mc_req_arbiter_pkg;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 512;
    localparam int MASK_W = DATA_W / 8;
    localparam int FLAG_W = 6;
    localparam int REG_RD_OFS = `REGULAR_READ_OFS;
    typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_RD = 2'd1, GNT_WR = 2'd2} gnt_e;
    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;
endpackage

// File: rtl/mc_req_slot.sv
// mc_req_slot: one-entry valid/ready holding register; can_take allows refill on the handshake cycle
module mc_req_slot
    import mc_req_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         can_take,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    slot_e state_q, state_d;
    logic [W-1:0] data_q, data_d;
    always_comb begin
        can_take = (state_q == SLOT_EMPTY) | out_ready;
        state_d = in_valid ? SLOT_FULL : (out_ready ? SLOT_EMPTY : state_q);
        data_d = in_valid ? in_data : data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
        end
    end
    assign out_valid = (state_q == SLOT_FULL);
    assign out_data = data_q;
endmodule

// File: rtl/mc_req_arbiter.sv
// mc_req_arbiter: read/write request arbiter with RAW ordering, read credit cap and return filter; ARB_STATS_EN adds grant statistics
module mc_req_arbiter
    import mc_req_arbiter_pkg::*;
#(
    parameter int MAX_RD_OUTSTANDING = 8,
    parameter int WR_STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_rden,
    input  logic [ADDR_W-1:0] arb_rdaddr,
    input  logic              arb_wren,
    input  logic [ADDR_W-1:0] arb_wraddr,
    input  logic [DATA_W-1:0] arb_wrdata,
    input  logic [MASK_W-1:0] arb_wrdata_mask,
    output logic              arb_rack,
    output logic              arb_wack,
    output logic [DATA_W-1:0] arb_rddata,
    output logic              arb_rdvalid,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] phy_rddata,
    input  logic              phy_rddata_valid,
    input  logic [FLAG_W-1:0] phy_rd_flag,
    output logic              rd_underflow
`ifdef ARB_STATS_EN
   ,output logic [31:0]       stat_rd_grants,
    output logic [31:0]       stat_wr_grants,
    output logic [15:0]       stat_starve_forces
`endif
);
    localparam int SW = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE_LIMIT);
    localparam logic [3:0] RD_MAX = 4'(MAX_RD_OUTSTANDING);
    gnt_e gnt;
    req_t slot_in, slot_out;
    logic can_take, slot_valid, rd_ok, force_wr, raw, rd_hs, ret, flags_unused;
    logic [3:0] rd_cnt_q, rd_cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic rdvalid_q, underflow_q, underflow_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    assign flags_unused = ^phy_rd_flag;
    // Credit is judged on the registered count only, so a same-cycle return never frees a slot early.
    always_comb begin
        rd_ok = arb_rden & (rd_cnt_q < RD_MAX);
        force_wr = arb_wren & (starve_q == STARVE_MAX);
        raw = arb_wren & arb_rden & (arb_wraddr == arb_rdaddr);
        gnt = (rst | ~can_take) ? GNT_NONE : (raw | force_wr) ? GNT_WR : rd_ok ? GNT_RD : arb_wren ? GNT_WR : GNT_NONE;
        arb_rack = (gnt == GNT_RD);
        arb_wack = (gnt == GNT_WR);
        slot_in = {arb_wack, arb_wack ? arb_wraddr : arb_rdaddr, arb_wrdata, arb_wrdata_mask};
        rd_hs = slot_valid & req_ready & ~slot_out.write;
        ret = phy_rddata_valid & phy_rd_flag[REG_RD_OFS];
        rd_cnt_d = (rd_hs & ~ret) ? rd_cnt_q + 4'd1 : (ret & ~rd_hs & (rd_cnt_q != 4'd0)) ? rd_cnt_q - 4'd1 : rd_cnt_q;
        underflow_d = underflow_q | (ret & (rd_cnt_q == 4'd0));
        starve_d = arb_wack ? '0 : ~arb_rack ? starve_q : ~arb_wren ? '0 : (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        rddata_d = ret ? phy_rddata : rddata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            starve_q <= '0;
            rdvalid_q <= 1'b0;
            rddata_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            starve_q <= starve_d;
            rdvalid_q <= ret;
            rddata_q <= rddata_d;
            underflow_q <= underflow_d;
        end
    end
    mc_req_slot #(.W($bits(req_t))) u_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (arb_rack | arb_wack),
        .in_data  (slot_in),
        .can_take (can_take),
        .out_valid(slot_valid),
        .out_ready(req_ready),
        .out_data (slot_out)
    );
    assign req_valid = slot_valid;
    assign req_write = slot_out.write;
    assign req_addr = slot_out.addr;
    assign req_wdata = slot_out.wdata;
    assign req_wmask = slot_out.wmask;
    assign arb_rdvalid = rdvalid_q;
    assign arb_rddata = rddata_q;
    assign rd_underflow = underflow_q;
`ifdef ARB_STATS_EN
    logic [31:0] rd_grants_q, rd_grants_d, wr_grants_q, wr_grants_d;
    logic [15:0] forces_q, forces_d;
    always_comb begin
        rd_grants_d = rd_grants_q + {31'd0, arb_rack};
        wr_grants_d = wr_grants_q + {31'd0, arb_wack};
        forces_d = forces_q + {15'd0, arb_wack & force_wr & ~raw};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_grants_q <= '0;
            wr_grants_q <= '0;
            forces_q <= '0;
        end else begin
            rd_grants_q <= rd_grants_d;
            wr_grants_q <= wr_grants_d;
            forces_q <= forces_d;
        end
    end
    assign stat_rd_grants = rd_grants_q;
    assign stat_wr_grants = wr_grants_q;
    assign stat_starve_forces = forces_q;
`endif
endmodule

// File: tb/tb_mc_req_arbiter.sv
// tb_mc_req_arbiter: randomized scoreboard bench for mc_req_arbiter against a rule-level reference model
module tb_mc_req_arbiter;
    import mc_req_arbiter_pkg::*;
    localparam int MAXRD = 8;
    localparam int LIMIT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic arb_rden = 0, arb_wren = 0, req_ready = 0, phy_rddata_valid = 0;
    logic [29:0] arb_rdaddr = '0, arb_wraddr = '0;
    logic [511:0] arb_wrdata = '0, phy_rddata = '0;
    logic [63:0] arb_wrdata_mask = '0;
    logic [5:0] phy_rd_flag = '0;
    logic arb_rack, arb_wack, arb_rdvalid, req_valid, req_write, rd_underflow;
    logic [511:0] arb_rddata, req_wdata;
    logic [29:0] req_addr;
    logic [63:0] req_wmask;
    mc_req_arbiter #(.MAX_RD_OUTSTANDING(MAXRD), .WR_STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .arb_rden(arb_rden), .arb_rdaddr(arb_rdaddr),
        .arb_wren(arb_wren), .arb_wraddr(arb_wraddr), .arb_wrdata(arb_wrdata), .arb_wrdata_mask(arb_wrdata_mask),
        .arb_rack(arb_rack), .arb_wack(arb_wack), .arb_rddata(arb_rddata), .arb_rdvalid(arb_rdvalid),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .phy_rddata(phy_rddata), .phy_rddata_valid(phy_rddata_valid), .phy_rd_flag(phy_rd_flag),
        .rd_underflow(rd_underflow)
    );
    typedef struct {
        bit           w;
        logic [29:0]  a;
        logic [511:0] d;
        logic [63:0]  m;
    } exp_t;
    exp_t exp_q[$];
    logic [511:0] ret_q[$];
    int tests = 0, fails = 0;
    int m_occ = 0, m_rdcnt = 0, m_starve = 0;
    bit m_slot_w = 0, m_uf = 0, rd_pend = 0, wr_pend = 0, same_addr = 0;
    int p_rd = 0, p_wr = 0, p_rdy = 0, p_ret = 0;
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [29:0] pick_addr();
        return same_addr ? (30'($urandom_range(1, 4)) << 8) : 30'($urandom);
    endfunction
    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction
    task automatic drive(input bit gen);
        if (gen && !rd_pend && $urandom_range(0, 99) < p_rd) begin
            rd_pend = 1;
            arb_rdaddr = pick_addr();
        end
        if (gen && !wr_pend && $urandom_range(0, 99) < p_wr) begin
            wr_pend = 1;
            arb_wraddr = pick_addr();
            arb_wrdata = rnd512();
            arb_wrdata_mask = {$urandom, $urandom};
        end
        arb_rden = rd_pend;
        arb_wren = wr_pend;
        req_ready = $urandom_range(0, 99) < p_rdy;
        phy_rddata_valid = $urandom_range(0, 99) < p_ret;
        phy_rd_flag = 6'($urandom);
        if (m_rdcnt == 0) phy_rd_flag[REG_RD_OFS] = 1'b0;
        phy_rddata = rnd512();
    endtask
    // Reference: apply the grant priority and counter rules to the inputs seen this cycle.
    task automatic step();
        int g;
        bit hs_rd, ret;
        exp_t e;
        @(negedge clk);
        g = 0;
        if (!rst && (m_occ == 0 || req_ready)) begin
            if (arb_wren && ((arb_rden && arb_wraddr == arb_rdaddr) || m_starve == LIMIT)) g = 2;
            else if (arb_rden && m_rdcnt < MAXRD) g = 1;
            else if (arb_wren) g = 2;
        end
        chk("arb_rack", arb_rack, g == 1);
        chk("arb_wack", arb_wack, g == 2);
        chk("req_valid", req_valid, m_occ);
        chk("rd_underflow", rd_underflow, m_uf);
        if (rst) begin
            m_occ = 0;
            m_rdcnt = 0;
            m_starve = 0;
            m_uf = 0;
            exp_q.delete();
        end else begin
            hs_rd = m_occ != 0 && req_ready && !m_slot_w;
            ret = phy_rddata_valid && phy_rd_flag[REG_RD_OFS];
            if (ret) ret_q.push_back(phy_rddata);
            if (ret && m_rdcnt == 0) m_uf = 1;
            if (hs_rd && !ret) m_rdcnt++;
            else if (ret && !hs_rd && m_rdcnt > 0) m_rdcnt--;
            if (g == 2) m_starve = 0;
            else if (g == 1) m_starve = arb_wren ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            if (g != 0) begin
                m_occ = 1;
                m_slot_w = (g == 2);
                e.w = (g == 2);
                e.a = (g == 2) ? arb_wraddr : arb_rdaddr;
                e.d = arb_wrdata;
                e.m = arb_wrdata_mask;
                exp_q.push_back(e);
            end else if (req_ready) m_occ = 0;
            if (g == 1) rd_pend = 0;
            if (g == 2) wr_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && req_valid && req_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL req_extra: handshake addr %0h write %0b with nothing expected", req_addr, req_write);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_write", req_write, e.w);
                    chk("req_addr", req_addr, e.a);
                    if (e.w) begin
                        chk("req_wdata", req_wdata, e.d);
                        chk("req_wmask", req_wmask, e.m);
                    end
                end
            end
        end
    end
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("arb_rdvalid", arb_rdvalid, ret_q.size() != 0);
            if (arb_rdvalid && ret_q.size() != 0) chk("arb_rddata", arb_rddata, ret_q.pop_front());
        end
    end
    initial begin
        int n;
        int cfg[3][4] = '{'{70, 30, 90, 5}, '{80, 80, 80, 40}, '{50, 50, 30, 30}};
        arb_rden = 1;
        arb_rdaddr = 30'h100;
        repeat (2) step();
        chk("reset req_addr", req_addr, 0);
        chk("reset req_write", req_write, 0);
        chk("reset arb_rddata", arb_rddata, 0);
        arb_rden = 0;
        rst = 0;
        for (int ph = 0; ph < 3; ph++) begin
            p_rd = cfg[ph][0];
            p_wr = cfg[ph][1];
            p_rdy = cfg[ph][2];
            p_ret = cfg[ph][3];
            same_addr = (ph == 1);
            repeat (600) begin
                drive(1);
                step();
            end
        end
        p_rdy = 100;
        p_ret = 50;
        n = 0;
        while ((m_occ != 0 || rd_pend || wr_pend) && n < 300) begin
            drive(0);
            step();
            n++;
        end
        tests++;
        if (m_occ != 0 || rd_pend || wr_pend) begin
            fails++;
            $display("FAIL drain: requests still pending after %0d cycles", n);
        end
        p_ret = 0;
        p_rdy = 0;
        repeat (2) begin
            drive(0);
            step();
        end
        rd_pend = 1;
        arb_rdaddr = 30'h100;
        drive(0);
        step();
        drive(0);
        step();
        rst = 1;
        drive(0);
        step();
        rst = 0;
        repeat (2) begin
            drive(0);
            step();
        end
        drive(0);
        phy_rddata_valid = 1;
        phy_rd_flag = 6'(1) << REG_RD_OFS;
        step();
        repeat (4) begin
            drive(0);
            step();
        end
        chk("exp_q drained", exp_q.size(), 0);
        chk("ret_q drained", ret_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
